button_pulse_multi: RTL and testbench

- N-channel successor to the single-button press/release pulse FSM.
- Per channel:
  - synchronises an active-low pushbutton;
  - debounces it over a parametrised window;
  - emits a one-clock pulse on release (legacy behaviour) or on press;
  - in press mode, optionally auto-repeats while the button is held.
- Sits between the board pushbuttons and the datapath/control logic of the 16-bit computer, e.g. single-step, register select and value increment.

---
 rtl/button_pulse_multi.sv | 119 +++++++++++
 tb/tb_button_pulse_multi.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_pulse_multi.sv
// N-channel pushbutton front end: two-flop synchroniser, debounce, press/release
// FSM and optional auto-repeat, emitting one registered pulse per channel event.
module button_pulse_multi #(
    parameter int unsigned N              = 4,
    parameter int unsigned DEBOUNCE       = 4,
    parameter bit          PULSE_ON_PRESS = 1'b0,
    parameter int unsigned REPEAT_DELAY   = 0,
    parameter int unsigned REPEAT_PERIOD  = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] button_in,
    output logic [N-1:0] pulse_out,
    output logic [N-1:0] held
);

    localparam int unsigned DB_W      = $clog2(DEBOUNCE + 1);
    localparam int unsigned REP_MAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned REP_W     = $clog2(REP_MAX + 1);
    localparam bit          REPEAT_EN = PULSE_ON_PRESS && (REPEAT_DELAY != 0);

    localparam logic [1:0] FREE     = 2'd0;
    localparam logic [1:0] PRESSED  = 2'd1;
    localparam logic [1:0] RELEASED = 2'd2;

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic             sync1_q, sync1_d;
        logic             sync2_q, sync2_d;
        logic             held_q, held_d;
        logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
        logic [1:0]       state_q, state_d;
        logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
        logic             rep_first_q, rep_first_d;
        logic             pulse_q, pulse_d;
        logic             press_evt;
        logic             rep_fire;
        logic [REP_W-1:0] rep_target;

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                sync1_q     <= 1'b1;
                sync2_q     <= 1'b1;
                held_q      <= 1'b0;
                db_cnt_q    <= '0;
                state_q     <= FREE;
                rep_cnt_q   <= '0;
                rep_first_q <= 1'b1;
                pulse_q     <= 1'b0;
            end else begin
                sync1_q     <= sync1_d;
                sync2_q     <= sync2_d;
                held_q      <= held_d;
                db_cnt_q    <= db_cnt_d;
                state_q     <= state_d;
                rep_cnt_q   <= rep_cnt_d;
                rep_first_q <= rep_first_d;
                pulse_q     <= pulse_d;
            end
        end

        always_comb begin
            sync1_d     = button_in[i];
            sync2_d     = sync1_q;
            held_d      = held_q;
            db_cnt_d    = '0;
            state_d     = state_q;
            rep_cnt_d   = rep_cnt_q;
            rep_first_d = rep_first_q;
            rep_fire    = 1'b0;
            pulse_d     = 1'b0;
            rep_target  = rep_first_q ? REP_W'(REPEAT_DELAY) : REP_W'(REPEAT_PERIOD);

            // Debounce: accept the inverted synchronised level after DEBOUNCE mismatching cycles
            if ((~sync2_q) != held_q) begin
                if (db_cnt_q + DB_W'(1) == DB_W'(DEBOUNCE)) begin
                    held_d = ~held_q;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end

            case (state_q)
                FREE:     if (held_q)  state_d = PRESSED;
                PRESSED:  if (!held_q) state_d = RELEASED;
                RELEASED: state_d = FREE;
                default:  state_d = FREE;
            endcase

            press_evt = (state_q == FREE) && held_q;

            // Repeat counter is gated by the next held level so a release cancels a due repeat
            if (!REPEAT_EN || !held_d) begin
                rep_cnt_d   = '0;
                rep_first_d = 1'b1;
            end else if (press_evt) begin
                rep_cnt_d   = '0;
                rep_first_d = 1'b1;
            end else if (state_q == PRESSED) begin
                if (rep_cnt_q + REP_W'(1) == rep_target) begin
                    rep_fire    = 1'b1;
                    rep_cnt_d   = '0;
                    rep_first_d = 1'b0;
                end else begin
                    rep_cnt_d = rep_cnt_q + REP_W'(1);
                end
            end

            if (PULSE_ON_PRESS) begin
                pulse_d = press_evt || rep_fire;
            end else begin
                pulse_d = (state_d == RELEASED);
            end
        end

        assign pulse_out[i] = pulse_q;
        assign held[i]      = held_q;
    end

endmodule

// File: tb/tb_button_pulse_multi.sv
// Directed bench for button_pulse_multi: release mode, bounce, press with repeat,
// simultaneous channels, single-cycle debounce and mid-operation reset.
module tb_button_pulse_multi;

    logic       clock;
    logic       reset;
    logic [3:0] btn_rel, btn_prs, btn_edge;
    logic [3:0] pulse_rel, held_rel;
    logic [3:0] pulse_prs, held_prs;
    logic [3:0] pulse_edge, held_edge;

    int checks   = 0;
    int failures = 0;

    button_pulse_multi #(
        .N(4), .DEBOUNCE(4), .PULSE_ON_PRESS(1'b0), .REPEAT_DELAY(0), .REPEAT_PERIOD(8)
    ) u_rel (
        .clock(clock), .reset(reset), .button_in(btn_rel), .pulse_out(pulse_rel), .held(held_rel)
    );

    button_pulse_multi #(
        .N(4), .DEBOUNCE(4), .PULSE_ON_PRESS(1'b1), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
    ) u_prs (
        .clock(clock), .reset(reset), .button_in(btn_prs), .pulse_out(pulse_prs), .held(held_prs)
    );

    button_pulse_multi #(
        .N(4), .DEBOUNCE(1), .PULSE_ON_PRESS(1'b1), .REPEAT_DELAY(3), .REPEAT_PERIOD(1)
    ) u_edge (
        .clock(clock), .reset(reset), .button_in(btn_edge), .pulse_out(pulse_edge), .held(held_edge)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic test_reset();
        btn_rel = 4'b0000;
        idle(3);
        checks++;
        if (held_rel !== 4'b0000 || pulse_rel !== 4'b0000) begin
            failures++;
            $display("FAIL reset_rel held=%b pulse=%b exp 0000/0000", held_rel, pulse_rel);
        end
        checks++;
        if (held_prs !== 4'b0000 || pulse_prs !== 4'b0000) begin
            failures++;
            $display("FAIL reset_prs held=%b pulse=%b exp 0000/0000", held_prs, pulse_prs);
        end
        checks++;
        if (held_edge !== 4'b0000 || pulse_edge !== 4'b0000) begin
            failures++;
            $display("FAIL reset_edge held=%b pulse=%b exp 0000/0000", held_edge, pulse_edge);
        end
        btn_rel = 4'b1111;
        step();
        reset = 1'b1;
        idle(10);
        checks++;
        if (held_rel !== 4'b0000 || pulse_rel !== 4'b0000) begin
            failures++;
            $display("FAIL post_reset_idle held=%b pulse=%b exp 0000/0000", held_rel, pulse_rel);
        end
    endtask

    task automatic test_release();
        logic [3:0] exp_h, exp_p;
        for (int e = 1; e <= 45; e++) begin
            if (e == 10) btn_rel[0] = 1'b0;
            if (e == 30) btn_rel[0] = 1'b1;
            step();
            exp_h = (e >= 15 && e < 35) ? 4'b0001 : 4'b0000;
            exp_p = (e == 36) ? 4'b0001 : 4'b0000;
            checks++;
            if (held_rel !== exp_h) begin
                failures++;
                $display("FAIL release_held e=%0d got=%b exp=%b", e, held_rel, exp_h);
            end
            checks++;
            if (pulse_rel !== exp_p) begin
                failures++;
                $display("FAIL release_pulse e=%0d got=%b exp=%b", e, pulse_rel, exp_p);
            end
        end
    endtask

    task automatic test_bounce();
        for (int e = 1; e <= 25; e++) begin
            btn_rel[1] = !((e >= 1 && e <= 3) || (e >= 6 && e <= 8));
            step();
            checks++;
            if (held_rel !== 4'b0000 || pulse_rel !== 4'b0000) begin
                failures++;
                $display("FAIL bounce e=%0d held=%b pulse=%b exp 0000/0000", e, held_rel, pulse_rel);
            end
        end
    endtask

    task automatic test_press_repeat();
        logic [3:0] exp_h, exp_p;
        for (int e = 1; e <= 75; e++) begin
            btn_prs[2] = !(e >= 1 && e <= 60);
            step();
            exp_h = (e >= 6 && e <= 65) ? 4'b0100 : 4'b0000;
            exp_p = (e == 7 || e == 27 || e == 35 || e == 43 || e == 51 || e == 59) ? 4'b0100 : 4'b0000;
            checks++;
            if (held_prs !== exp_h) begin
                failures++;
                $display("FAIL repeat_held e=%0d got=%b exp=%b", e, held_prs, exp_h);
            end
            checks++;
            if (pulse_prs !== exp_p) begin
                failures++;
                $display("FAIL repeat_pulse e=%0d got=%b exp=%b", e, pulse_prs, exp_p);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] exp_h, exp_p;
        for (int e = 1; e <= 25; e++) begin
            btn_rel = (e <= 10) ? 4'b0000 : 4'b1111;
            step();
            exp_h = (e >= 6 && e <= 15) ? 4'b1111 : 4'b0000;
            exp_p = (e == 17) ? 4'b1111 : 4'b0000;
            checks++;
            if (held_rel !== exp_h) begin
                failures++;
                $display("FAIL simul_held e=%0d got=%b exp=%b", e, held_rel, exp_h);
            end
            checks++;
            if (pulse_rel !== exp_p) begin
                failures++;
                $display("FAIL simul_pulse e=%0d got=%b exp=%b", e, pulse_rel, exp_p);
            end
        end
    endtask

    task automatic test_edge_fast();
        logic [3:0] exp_h, exp_p;
        for (int e = 1; e <= 45; e++) begin
            btn_edge[0] = !(e == 1 || (e >= 11 && e <= 30));
            step();
            exp_h = (e == 3 || (e >= 13 && e <= 32)) ? 4'b0001 : 4'b0000;
            exp_p = (e == 4 || e == 14 || (e >= 17 && e <= 32)) ? 4'b0001 : 4'b0000;
            checks++;
            if (held_edge !== exp_h) begin
                failures++;
                $display("FAIL fast_held e=%0d got=%b exp=%b", e, held_edge, exp_h);
            end
            checks++;
            if (pulse_edge !== exp_p) begin
                failures++;
                $display("FAIL fast_pulse e=%0d got=%b exp=%b", e, pulse_edge, exp_p);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp_h, exp_p;
        btn_prs[0] = 1'b0;
        idle(7);
        checks++;
        if (pulse_prs !== 4'b0001 || held_prs !== 4'b0001) begin
            failures++;
            $display("FAIL midrst_pre pulse=%b held=%b exp 0001/0001", pulse_prs, held_prs);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (pulse_prs !== 4'b0000 || held_prs !== 4'b0000) begin
            failures++;
            $display("FAIL midrst_async pulse=%b held=%b exp 0000/0000", pulse_prs, held_prs);
        end
        idle(3);
        checks++;
        if (pulse_prs !== 4'b0000 || held_prs !== 4'b0000) begin
            failures++;
            $display("FAIL midrst_hold pulse=%b held=%b exp 0000/0000", pulse_prs, held_prs);
        end
        reset = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            step();
            exp_h = (e >= 6) ? 4'b0001 : 4'b0000;
            exp_p = (e == 7) ? 4'b0001 : 4'b0000;
            checks++;
            if (held_prs !== exp_h) begin
                failures++;
                $display("FAIL midrst_held e=%0d got=%b exp=%b", e, held_prs, exp_h);
            end
            checks++;
            if (pulse_prs !== exp_p) begin
                failures++;
                $display("FAIL midrst_pulse e=%0d got=%b exp=%b", e, pulse_prs, exp_p);
            end
        end
        btn_prs[0] = 1'b1;
        idle(10);
    endtask

    initial begin
        reset    = 1'b0;
        btn_rel  = 4'b1111;
        btn_prs  = 4'b1111;
        btn_edge = 4'b1111;
        test_reset();
        test_release();
        idle(5);
        test_bounce();
        idle(5);
        test_press_repeat();
        idle(5);
        test_simultaneous();
        idle(5);
        test_edge_fast();
        idle(5);
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
